// File: rtl/bsg_link_credit_arbiter_pkg.sv
// bsg_link_arb_pkg: shared types and elaboration helpers for the credit arbiter.
// Contents: FSM state enum, credit counter width function, credit/token ratio check.
// Latency/backpressure: n/a (no logic).
package bsg_link_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,  // output register empty
    HOLD = 1'b1   // output register full, link_valid_o asserted
  } arb_state_e;

  // Width of a counter that must hold values 0..credits inclusive.
  function automatic int credit_width(input int credits);
    return $clog2(credits + 1);
  endfunction

  // Token returns must land exactly on the credit ceiling, otherwise a
  // fully drained link could never be refilled without saturating.
  function automatic bit ratio_ok(input int credits, input int token_ratio);
    return (token_ratio > 0) && ((credits % token_ratio) == 0);
  endfunction

  localparam int  DEFAULT_CREDITS     = 16;
  localparam int  DEFAULT_TOKEN_RATIO = 4;
  localparam bit  DEFAULT_RATIO_OK    = ratio_ok(DEFAULT_CREDITS, DEFAULT_TOKEN_RATIO);

endpackage

// File: rtl/bsg_link_credit_arbiter_if.sv
// bsg_link_credit_arbiter_if: requester-side and link-side handshake bundle.
// slave modport = arbiter view; master modport = requesters + upstream link view.
// Latency/backpressure: n/a (wires only); req_ready_o / link_ready_i carry backpressure.
interface bsg_link_credit_arbiter_if
  import bsg_link_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 64
);

  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ*WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic                     link_valid_o;
  logic [WIDTH-1:0]         link_data_o;
  logic                     link_ready_i;

  modport slave (
    input  req_valid_i, req_data_i, link_ready_i,
    output req_ready_o, link_valid_o, link_data_o
  );

  modport master (
    output req_valid_i, req_data_i, link_ready_i,
    input  req_ready_o, link_valid_o, link_data_o
  );

endinterface

// File: rtl/bsg_link_credit_arbiter_rr_picker.sv
// bsg_link_rr_picker: picks one valid requester, searching upward from ptr_i with wrap.
// Ports: valid_i/ptr_i in; grant_o (one-hot), idx_o (encoded), any_o out. Purely combinational.
// Build option: BSG_LINK_ARB_FIXED_PRIORITY_EN turns it into a lowest-index-wins encoder.
module bsg_link_rr_picker
  import bsg_link_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     idx_o,
  output logic               any_o
);

  assign any_o = |valid_i;

`ifdef BSG_LINK_ARB_FIXED_PRIORITY_EN
  // Pointer is meaningless here; fold it away.
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  // Walk from the top down so the lowest valid index is the last writer.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_i[k]) begin
        grant_o    = '0;
        grant_o[k] = 1'b1;
        idx_o      = IDW'(k);
      end
    end
  end
`else
  int           cand;
  logic [IDW:0] cand_idx;
  logic         found;

  // Candidate order is ptr, ptr+1, ... wrapping at NUM_REQ; first valid wins.
  always_comb begin
    grant_o  = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(ptr_i) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = (IDW+1)'(cand);
      if (!found && valid_i[cand_idx[IDW-1:0]]) begin
        found                      = 1'b1;
        grant_o[cand_idx[IDW-1:0]] = 1'b1;
        idx_o                      = cand_idx[IDW-1:0];
      end
    end
  end
`endif

endmodule

// File: rtl/bsg_link_credit_arbiter.sv
// bsg_link_credit_arbiter: credit-gated round-robin mux of NUM_REQ requesters onto one link port.
// Latency: req_valid_i -> link_valid_o one cycle when credit is available; 1 pkt/cycle back-to-back.
// Backpressure: output register holds until link_ready_i; no credit => req_ready_o all zero.
// Ports: clk/rst (sync, active-high); bus (slave modport: req_*, link_*); token_i credit return
// pulse; credits_o live credit count; grant_id_o source of held packet; err_o sticky overflow.
// Build option: BSG_LINK_ARB_FIXED_PRIORITY_EN selects fixed lowest-index priority.
module bsg_link_credit_arbiter
  import bsg_link_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 64,
  parameter int CREDITS     = DEFAULT_CREDITS,
  parameter int TOKEN_RATIO = DEFAULT_TOKEN_RATIO,
  parameter int CW          = credit_width(CREDITS),
  parameter int IDW         = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  bsg_link_credit_arbiter_if.slave     bus,
  input  logic                         token_i,
  output logic [CW-1:0]                credits_o,
  output logic [IDW-1:0]               grant_id_o,
  output logic                         err_o
);

  localparam bit RATIO_OK = ratio_ok(CREDITS, TOKEN_RATIO);

  if (!RATIO_OK) begin : g_bad_ratio
    $error("bsg_link_credit_arbiter: TOKEN_RATIO must divide CREDITS");
  end

  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(CREDITS);
  localparam logic [CW:0] RATIO_W    = (CW+1)'(TOKEN_RATIO);
  localparam logic [CW:0] ONE_W      = (CW+1)'(1);

  arb_state_e       state_r;
  logic             link_valid_r;
  logic [WIDTH-1:0] link_data_r;
  logic [IDW-1:0]   grant_id_r;
  logic [CW-1:0]    credits_r;
  logic             err_r;
  logic [IDW-1:0]   ptr;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;
  logic               slot_free;
  logic               load;
  logic [CW:0]        credit_sum;
  logic               credit_ovf;

`ifdef BSG_LINK_ARB_FIXED_PRIORITY_EN
  assign ptr = '0;
`else
  logic [IDW-1:0] ptr_r;
  assign ptr = ptr_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (load) begin
      ptr_r <= (pick_idx == IDW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end
`endif

  bsg_link_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_picker (
    .valid_i (bus.req_valid_i),
    .ptr_i   (ptr),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // The output register can take a new packet when empty, or in the same
  // cycle the link drains it (this is what gives 1 pkt/cycle streaming).
  assign slot_free = (state_r == IDLE) || bus.link_ready_i;

  // Only the current count gates loading; a token arriving this cycle is
  // visible to the load decision one cycle later.
  assign load = pick_any && (credits_r != '0) && slot_free;

  assign bus.req_ready_o = load ? pick_grant : '0;

  // Load and token are netted together. load implies credits_r >= 1, so
  // the subtraction cannot underflow; one extra bit catches overshoot.
  always_comb begin
    credit_sum = {1'b0, credits_r};
    if (load)    credit_sum = credit_sum - ONE_W;
    if (token_i) credit_sum = credit_sum + RATIO_W;
    credit_ovf = (credit_sum > CREDIT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      link_valid_r <= 1'b0;
      link_data_r  <= '0;
      grant_id_r   <= '0;
      credits_r    <= CW'(CREDITS);
      err_r        <= 1'b0;
    end else begin
      credits_r <= credit_ovf ? CW'(CREDITS) : credit_sum[CW-1:0];
      if (credit_ovf) err_r <= 1'b1;

      case (state_r)
        IDLE: begin
          if (load) begin
            state_r      <= HOLD;
            link_valid_r <= 1'b1;
            link_data_r  <= bus.req_data_i[pick_idx*WIDTH +: WIDTH];
            grant_id_r   <= pick_idx;
          end
        end
        HOLD: begin
          if (load) begin
            // Handshake and refill in the same cycle: stay in HOLD.
            link_data_r <= bus.req_data_i[pick_idx*WIDTH +: WIDTH];
            grant_id_r  <= pick_idx;
          end else if (bus.link_ready_i) begin
            state_r      <= IDLE;
            link_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r      <= IDLE;
          link_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.link_valid_o = link_valid_r;
  assign bus.link_data_o  = link_data_r;
  assign grant_id_o       = grant_id_r;
  assign credits_o        = credits_r;
  assign err_o            = err_r;

endmodule

// File: tb/tb_bsg_link_credit_arbiter.sv
// Bench for bsg_link_credit_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue-free behavioural model.
module tb_bsg_link_credit_arbiter;
  import bsg_link_arb_pkg::*;

  localparam int N   = 4;
  localparam int W   = 64;
  localparam int CR  = 16;
  localparam int TR  = 4;
  localparam int CW  = credit_width(CR);
  localparam int IDW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           token_i = 1'b0;
  logic [CW-1:0]  credits_o;
  logic [IDW-1:0] grant_id_o;
  logic           err_o;

  bsg_link_credit_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  bsg_link_credit_arbiter #(
    .NUM_REQ(N), .WIDTH(W), .CREDITS(CR), .TOKEN_RATIO(TR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .token_i    (token_i),
    .credits_o  (credits_o),
    .grant_id_o (grant_id_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: what the output register should hold, in plain integers.
  bit          m_hold;
  logic [63:0] m_data;
  int          m_id;
  int          m_cred;
  bit          m_err;
  int          m_ptr;
  logic [N-1:0] last_rdy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hold = 0; m_data = '0; m_id = 0; m_cred = CR; m_err = 0; m_ptr = 0;
  endtask

  // Called at posedge+1. Applies inputs, checks at the negedge, advances the model
  // across the next posedge and returns at posedge+1.
  task automatic drive(input bit r, input logic [N-1:0] v, input bit rdy, input bit tk);
    bit           can_load;
    int           w;
    logic [N-1:0] exp_rdy;
    int           nc;
    rst = r; bus.req_valid_i = v; bus.link_ready_i = rdy; token_i = tk;
    @(negedge clk);

    w = -1;
`ifdef BSG_LINK_ARB_FIXED_PRIORITY_EN
    for (int k = 0; k < N; k++) if (w < 0 && v[k]) w = k;
`else
    for (int k = 0; k < N; k++) if (w < 0 && v[(m_ptr + k) % N]) w = (m_ptr + k) % N;
`endif
    can_load = (w >= 0) && (m_cred > 0) && (!m_hold || rdy);
    exp_rdy  = '0;
    if (can_load) exp_rdy[w] = 1'b1;

    last_rdy = bus.req_ready_o;
    chk("link_valid", 64'(bus.link_valid_o), 64'(m_hold));
    chk("link_data",  bus.link_data_o, m_data);
    chk("grant_id",   64'(grant_id_o), 64'(m_id));
    chk("credits",    64'(credits_o), 64'(m_cred));
    chk("err",        64'(err_o), 64'(m_err));
    if (!r) chk("req_ready", 64'(bus.req_ready_o), 64'(exp_rdy));

    if (r) begin
      model_reset();
    end else begin
      if (can_load) begin
        m_hold = 1; m_data = bus.req_data_i[w*W +: W]; m_id = w; m_ptr = (w + 1) % N;
      end else if (m_hold && rdy) begin
        m_hold = 0;
      end
      nc = m_cred - (can_load ? 1 : 0) + (tk ? TR : 0);
      if (nc > CR) begin nc = CR; m_err = 1; end
      m_cred = nc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int k = 0; k < N*W/32; k++) bus.req_data_i[k*32 +: 32] = $urandom;
  endtask

  task automatic do_reset();
    drive(1, '0, 1, 0);
    drive(1, '0, 1, 0);
  endtask

  initial begin
    bus.req_valid_i = '0; bus.link_ready_i = 1'b1; bus.req_data_i = '0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Reset state
    chk("rst_valid",   64'(bus.link_valid_o), 64'd0);
    chk("rst_credits", 64'(credits_o), 64'd16);
    chk("rst_err",     64'(err_o), 64'd0);
    chk("rst_gid",     64'(grant_id_o), 64'd0);

    // Single requester, one-cycle latency
    rand_data();
    bus.req_data_i[0 +: W] = 64'hDEAD;
    drive(0, 4'b0001, 1, 0);
    chk("single_rdy",   64'(last_rdy), 64'h1);
    chk("single_valid", 64'(bus.link_valid_o), 64'd1);
    chk("single_data",  bus.link_data_o, 64'hDEAD);
    chk("single_cred",  64'(credits_o), 64'd15);

    // Four requesters streaming until credits run out
    do_reset();
    for (int k = 0; k < 16; k++) begin
      rand_data();
      drive(0, 4'b1111, 1, 0);
`ifdef BSG_LINK_ARB_FIXED_PRIORITY_EN
      chk("rr_order", 64'(grant_id_o), 64'd0);
`else
      chk("rr_order", 64'(grant_id_o), 64'(k % 4));
`endif
    end
    chk("drain_cred", 64'(credits_o), 64'd0);
    drive(0, 4'b1111, 1, 0);
    chk("drain_rdy",   64'(last_rdy), 64'd0);
    chk("drain_valid", 64'(bus.link_valid_o), 64'd0);

    // Token at zero credit: refill visible next cycle, load the cycle after
    drive(0, 4'b1111, 1, 1);
    chk("tok_no_load", 64'(last_rdy), 64'd0);
    chk("tok_cred",    64'(credits_o), 64'd4);
    for (int k = 0; k < 4; k++) begin
      rand_data();
      drive(0, 4'b1111, 1, 0);
      chk("tok_load", 64'(last_rdy != '0), 64'd1);
    end
    chk("tok_cred0", 64'(credits_o), 64'd0);
    drive(0, 4'b1111, 1, 0);
    chk("tok_stall", 64'(last_rdy), 64'd0);

    // Link stall while holding
    do_reset();
    rand_data();
    drive(0, 4'b0010, 1, 0);
    for (int k = 0; k < 5; k++) begin
      drive(0, 4'b1111, 0, 0);
      chk("stall_rdy",  64'(last_rdy), 64'd0);
      chk("stall_gid",  64'(grant_id_o), 64'd1);
      chk("stall_cred", 64'(credits_o), 64'd15);
    end

    // Overflow: token at full credit, then load+token at 15
    do_reset();
    drive(0, 4'b0000, 1, 1);
    chk("ovf_cred", 64'(credits_o), 64'd16);
    chk("ovf_err",  64'(err_o), 64'd1);
    drive(0, 4'b0000, 1, 0);
    drive(0, 4'b0000, 1, 0);
    chk("ovf_sticky", 64'(err_o), 64'd1);
    do_reset();
    drive(0, 4'b0001, 1, 0);
    drive(0, 4'b0001, 1, 1);
    chk("net_cred", 64'(credits_o), 64'd16);
    chk("net_err",  64'(err_o), 64'd1);

    // Reset while holding with 9 credits
    do_reset();
    for (int k = 0; k < 7; k++) begin rand_data(); drive(0, 4'b1111, 1, 0); end
    chk("pre_rst_cred", 64'(credits_o), 64'd9);
    drive(1, 4'b1111, 0, 0);
    chk("mid_rst_valid", 64'(bus.link_valid_o), 64'd0);
    chk("mid_rst_cred",  64'(credits_o), 64'd16);
    chk("mid_rst_err",   64'(err_o), 64'd0);
    drive(0, 4'b1111, 1, 0);
    chk("mid_rst_first", 64'(last_rdy), 64'h1);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rand_data();
      drive(($urandom_range(0, 99) == 0), N'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 5) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
